// File: rtl/fft_seq_pkg.sv
// Shared definitions for the 4-lane N=128 FFT stage sequencer.
// Holds the FFT geometry defaults, output field widths, internal counter
// widths and the sequencer state encoding.
package fft_seq_pkg;

    localparam int N        = 128;
    localparam int LANES    = 4;
    localparam int STAGES   = 7;                 // log2(N)
    localparam int WORDS    = N / LANES;         // coefficient words per stage per lane
    localparam int PIPE_LAT = 3;                 // bf_en to bf_valid latency

    localparam int COEFF_AW = 5;
    localparam int STAGE_W  = 3;

    localparam int WORD_W    = $clog2(WORDS);
    localparam int STG_CNT_W = $clog2(STAGES);
    localparam int GAP_W     = $clog2(PIPE_LAT + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/fft_valid_delay.sv
// Fixed-depth shift register used to delay enable/valid/stage fields.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage to 0
//   d_i  - W-bit input word
//   q_o  - d_i delayed by DEPTH cycles (DEPTH >= 1)
module fft_valid_delay
    import fft_seq_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame controller for the 4-lane N=128 FFT. On an accepted start it walks
// the STAGES butterfly stages, issuing WORDS coefficient ROM reads per stage,
// with PIPE_LAT idle cycles between stages and PIPE_LAT+1 drain cycles after
// the last stage, then pulses frame_done_o.
//
// Handshake: a frame starts on the clock edge where ready_o & start_i are both
// 1. start_i high on any other edge is ignored and flagged on start_drop_o in
// the following cycle.
//
// Optional build macro FFT_SEQ_STALL_EN: when defined, stall_i high in
// RUN/GAP/DRAIN freezes the FSM and counters and suppresses coeff_en_o, while
// the butterfly delay lines keep shifting. When undefined stall_i is ignored.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start_i        - frame start request
//   stall_i        - freeze request (stall build only)
//   ready_o        - high in IDLE
//   coeff_en_o     - coefficient ROM read enable
//   coeff_addr_o   - coefficient ROM word address
//   stage_o        - stage index aligned with coeff_en_o
//   bf_en_o        - butterfly enable (coeff_en_o + 1 cycle ROM latency)
//   bf_stage_o     - stage_o delayed 1 cycle
//   bf_valid_o     - bf_en_o delayed PIPE_LAT cycles
//   frame_done_o   - one-cycle pulse after the last bf_valid_o
//   start_drop_o   - one-cycle pulse for an ignored start request
module fft_stage_sequencer
    import fft_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stall_i,
    output logic                ready_o,
    output logic                coeff_en_o,
    output logic [COEFF_AW-1:0] coeff_addr_o,
    output logic [STAGE_W-1:0]  stage_o,
    output logic                bf_en_o,
    output logic [STAGE_W-1:0]  bf_stage_o,
    output logic                bf_valid_o,
    output logic                frame_done_o,
    output logic                start_drop_o
);

    localparam logic [WORD_W-1:0]    LAST_WORD  = WORD_W'(WORDS - 1);
    localparam logic [STG_CNT_W-1:0] LAST_STAGE = STG_CNT_W'(STAGES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(PIPE_LAT - 1);
    localparam logic [GAP_W-1:0]     DRAIN_LAST = GAP_W'(PIPE_LAT);

    seq_state_e             state_q, state_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [STG_CNT_W-1:0]   stage_q, stage_d;
    logic [GAP_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   coeff_en_q, coeff_en_d;
    logic [COEFF_AW-1:0]    addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;
    logic                   stall;

`ifdef FFT_SEQ_STALL_EN
    assign stall = stall_i && (state_q inside {RUN, GAP, DRAIN});
`else
    logic unused_stall;
    assign unused_stall = stall_i;
    assign stall        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            stage_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            coeff_en_q <= 1'b0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            coeff_en_q <= coeff_en_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    word_d  = '0;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (word_q == LAST_WORD) begin
                    word_d  = '0;
                    cnt_d   = '0;
                    state_d = (stage_q == LAST_STAGE) ? DRAIN : GAP;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    stage_d = stage_q + 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stall overrides every advance decided above.
        if (stall) begin
            state_d = state_q;
            word_d  = word_q;
            stage_d = stage_q;
            cnt_d   = cnt_q;
        end

        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        ready_d    = (state_d == IDLE);
        coeff_en_d = (state_d == RUN) && !stall;
        addr_d     = coeff_en_d ? COEFF_AW'(word_d) : addr_q;
        done_d     = (state_d == DONE);
        drop_d     = start_i && (state_q != IDLE);
    end

    // ROM read latency: coefficient fields become butterfly fields one cycle later.
    logic [STAGE_W:0] bf_q;

    fft_valid_delay #(
        .DEPTH (1),
        .W     (STAGE_W + 1)
    ) u_bf_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({coeff_en_q, STAGE_W'(stage_q)}),
        .q_o (bf_q)
    );

    fft_valid_delay #(
        .DEPTH (PIPE_LAT),
        .W     (1)
    ) u_valid_dly (
        .clk (clk),
        .rst (rst),
        .d_i (bf_q[STAGE_W]),
        .q_o (bf_valid_o)
    );

    assign ready_o      = ready_q;
    assign coeff_en_o   = coeff_en_q;
    assign coeff_addr_o = addr_q;
    assign stage_o      = STAGE_W'(stage_q);
    assign bf_en_o      = bf_q[STAGE_W];
    assign bf_stage_o   = bf_q[STAGE_W-1:0];
    assign frame_done_o = done_q;
    assign start_drop_o = drop_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer. Expected per-cycle outputs
// come from a frame schedule built with plain loops over stages/words/gaps,
// with stalled cycles modelled as repeats of the stalled cycle's picture.
module tb_fft_stage_sequencer;
    import fft_seq_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i;
    logic                stall_i;
    logic                ready_o;
    logic                coeff_en_o;
    logic [COEFF_AW-1:0] coeff_addr_o;
    logic [STAGE_W-1:0]  stage_o;
    logic                bf_en_o;
    logic [STAGE_W-1:0]  bf_stage_o;
    logic                bf_valid_o;
    logic                frame_done_o;
    logic                start_drop_o;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fft_stage_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .ready_o      (ready_o),
        .coeff_en_o   (coeff_en_o),
        .coeff_addr_o (coeff_addr_o),
        .stage_o      (stage_o),
        .bf_en_o      (bf_en_o),
        .bf_stage_o   (bf_stage_o),
        .bf_valid_o   (bf_valid_o),
        .frame_done_o (frame_done_o),
        .start_drop_o (start_drop_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic                ready;
        logic                en;
        logic [COEFF_AW-1:0] addr;
        logic [STAGE_W-1:0]  stage;
        logic                bf_en;
        logic [STAGE_W-1:0]  bf_stage;
        logic                bf_valid;
        logic                done;
        logic                drop;
    } out_t;

    typedef struct {
        logic start;
        logic stall;
        out_t exp;
        out_t mask;
    } vec_t;

    vec_t tv[$];
    bit   start_at [1024];
    bit   stall_at [1024];
    int   model_done;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 1024; i++) begin
            start_at[i] = 1'b0;
            stall_at[i] = 1'b0;
        end
    endtask

    function automatic out_t get_out();
        out_t o;
        o.ready    = ready_o;
        o.en       = coeff_en_o;
        o.addr     = coeff_addr_o;
        o.stage    = stage_o;
        o.bf_en    = bf_en_o;
        o.bf_stage = bf_stage_o;
        o.bf_valid = bf_valid_o;
        o.done     = frame_done_o;
        o.drop     = start_drop_o;
        return o;
    endfunction

    function automatic out_t idle_exp();
        out_t o;
        o       = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int k, input out_t act,
                             input out_t exp, input out_t mask);
        n_tests++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got rdy=%0b en=%0b addr=%0d stg=%0d bfen=%0b bfstg=%0d bfv=%0b done=%0b drop=%0b, expected rdy=%0b en=%0b addr=%0d stg=%0d bfen=%0b bfstg=%0d bfv=%0b done=%0b drop=%0b",
                     name, k, act.ready, act.en, act.addr, act.stage, act.bf_en, act.bf_stage,
                     act.bf_valid, act.done, act.drop, exp.ready, exp.en, exp.addr, exp.stage,
                     exp.bf_en, exp.bf_stage, exp.bf_valid, exp.done, exp.drop);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame schedule: per stage WORDS reads then PIPE_LAT idle cycles, the
    // last stage followed by PIPE_LAT+1 drain cycles, then one done cycle.
    function automatic void build_frame();
        out_t sched[$];
        out_t pic[$];
        out_t e;
        out_t m;
        vec_t v;
        int   t;
        int   i;
        bit   rep;

        tv.delete();
        for (int s = 0; s < STAGES; s++) begin
            for (int w = 0; w < WORDS; w++) begin
                e = '0; e.en = 1'b1; e.addr = COEFF_AW'(w); e.stage = STAGE_W'(s);
                sched.push_back(e);
            end
            if (s < STAGES - 1) begin
                for (int g = 0; g < PIPE_LAT; g++) begin
                    e = '0; e.addr = COEFF_AW'(WORDS - 1); e.stage = STAGE_W'(s);
                    sched.push_back(e);
                end
            end
        end
        for (int d = 0; d < PIPE_LAT + 1; d++) begin
            e = '0; e.addr = COEFF_AW'(WORDS - 1); e.stage = STAGE_W'(STAGES - 1);
            sched.push_back(e);
        end

        pic.push_back(idle_exp());
        t = 1; i = 0; rep = 1'b0;
        while (i < sched.size()) begin
            e = sched[i];
            if (rep) e.en = 1'b0;
            pic.push_back(e);
`ifdef FFT_SEQ_STALL_EN
            if (stall_at[t]) rep = 1'b1;
            else begin rep = 1'b0; i++; end
`else
            i++;
`endif
            t++;
        end
        model_done = t;
        e = '0; e.done = 1'b1; e.addr = COEFF_AW'(WORDS - 1); e.stage = STAGE_W'(STAGES - 1);
        pic.push_back(e);
        e = idle_exp(); e.addr = COEFF_AW'(WORDS - 1); e.stage = STAGE_W'(STAGES - 1);
        pic.push_back(e);

        for (int k = 0; k < pic.size(); k++) begin
            e = pic[k];
            e.bf_en    = (k >= 1) ? pic[k-1].en : 1'b0;
            e.bf_stage = (k >= 1) ? pic[k-1].stage : '0;
            e.bf_valid = (k >= PIPE_LAT + 1) ? pic[k-PIPE_LAT-1].en : 1'b0;
            e.drop     = (k >= 1) && start_at[k-1] && (k - 1 >= 1) && (k - 1 <= model_done);
            m = '1;
            if (!e.en)    m.stage    = '0;
            if (!e.bf_en) m.bf_stage = '0;
            if (k == pic.size() - 1) m.addr = '0;
            v.start = start_at[k];
            v.stall = stall_at[k];
            v.exp   = e;
            v.mask  = m;
            tv.push_back(v);
        end
    endfunction

    // ---------------- driver ----------------
    task automatic apply_frame(input string name, input int exp_done, input int exp_drops);
        out_t a;
        int   n_done  = 0;
        int   n_valid = 0;
        int   n_drop  = 0;
        int   done_at = -1;
        for (int k = 0; k < tv.size(); k++) begin
            a = get_out();
            check_out(name, k, a, tv[k].exp, tv[k].mask);
            if (a.done) begin n_done++; done_at = k; end
            if (a.bf_valid) n_valid++;
            if (a.drop) n_drop++;
            start_i = tv[k].start;
            stall_i = tv[k].stall;
            next_cycle();
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        check({name, " done cycle"}, done_at, exp_done);
        check({name, " done count"}, n_done, 1);
        check({name, " bf_valid pulses"}, n_valid, STAGES * WORDS);
        check({name, " drop pulses"}, n_drop, exp_drops);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n_starts;
        int s0;
        int slen;
        int first_done;
        int second_done;
        int drops;
        int saw_done;

        rst     = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;

        // Reset then idle, stall toggling must have no effect in IDLE.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            check_out("idle", k, get_out(), idle_exp(), '1);
            stall_i = 1'($urandom_range(0, 1));
            next_cycle();
        end
        stall_i = 1'b0;

        // Single frame.
        clear_stim();
        start_at[0] = 1'b1;
        build_frame();
        do_reset();
        apply_frame("single", 247, 0);

        // Starts at 0, 50 and 247 (the DONE cycle): two drops, one frame.
        clear_stim();
        start_at[0] = 1'b1; start_at[50] = 1'b1; start_at[247] = 1'b1;
        build_frame();
        do_reset();
        apply_frame("drops", 247, 2);

        // Five stall cycles in stage 3 RUN.
        clear_stim();
        start_at[0] = 1'b1;
        for (int c = 110; c < 115; c++) stall_at[c] = 1'b1;
        build_frame();
        do_reset();
`ifdef FFT_SEQ_STALL_EN
        apply_frame("stall5", 252, 0);
`else
        apply_frame("stall5", 247, 0);
`endif

        // Randomised frames: random stall window and random ignored starts.
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            start_at[0] = 1'b1;
            s0   = $urandom_range(1, 250);
            slen = $urandom_range(1, 8);
            for (int c = s0; c < s0 + slen; c++) stall_at[c] = 1'b1;
            for (int j = 0; j < 3; j++) start_at[$urandom_range(1, 246)] = 1'b1;
            n_starts = 0;
            for (int c = 1; c < 247; c++) if (start_at[c]) n_starts++;
            build_frame();
            do_reset();
            apply_frame($sformatf("rand%0d", r), model_done, n_starts);
        end

        // Back-to-back: start held high across two frames.
        do_reset();
        start_i     = 1'b1;
        first_done  = -1;
        second_done = -1;
        drops       = 0;
        for (int k = 0; k < 600 && second_done < 0; k++) begin
            if (frame_done_o) begin
                if (first_done < 0) first_done = k;
                else second_done = k;
            end
            if (start_drop_o && k <= 248) drops++;
            if (k == 248) check("b2b ready after done", 32'(ready_o), 1);
            next_cycle();
        end
        start_i = 1'b0;
        check("b2b first done", first_done, 247);
        check("b2b second done", second_done, 495);
        check("b2b drops first frame", drops, 247);
        for (int k = 0; k < 4; k++) next_cycle();

        // Reset mid stage 2 aborts the frame silently.
        do_reset();
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        for (int k = 1; k < 100; k++) next_cycle();
        check("midrst stage at 100", 32'(stage_o), 2);
        check("midrst addr at 100", 32'(coeff_addr_o), 29);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_out("midrst after reset", 101, get_out(), idle_exp(), '1);
        saw_done = 0;
        for (int k = 0; k < 200; k++) begin
            if (frame_done_o || coeff_en_o) saw_done++;
            next_cycle();
        end
        check("midrst no activity", saw_done, 0);
        clear_stim();
        start_at[0] = 1'b1;
        build_frame();
        apply_frame("after midrst", 247, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
